// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] sel);
    onehot2      = '0;
    onehot2[sel] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after ptr, wrapping mod 4.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);
  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // scan ptr+1 .. ptr+4; the 2-bit add wraps naturally
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;
endmodule

// File: rtl/rr_arbiter4_4bits.sv
// Round-robin arbiter feeding one shared word channel with valid/ready.
// Optional burst lock (keep winner's priority) enabled by ARB_LOCK_EN.
module rr_arbiter4_4bits
  import rr_arb_pkg::*;
#(
  parameter int               DATA_W  = 4,
  parameter logic [SEL_W-1:0] RST_PTR = 2'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]  lock,
`endif
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  ack,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] words [N_REQ];
  logic [SEL_W-1:0]  winner;
  logic              any_req;
  logic              hs;
  logic              keep;

  assign words[0] = in0;
  assign words[1] = in1;
  assign words[2] = in2;
  assign words[3] = in3;

`ifdef ARB_LOCK_EN
  assign keep = lock[sel_q];
`else
  assign keep = 1'b0;
`endif

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign hs = (state_q == GRANT) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= RST_PTR;
      sel_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (hs)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Words are captured only on the IDLE->GRANT edge; sel/data persist after.
  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    gnt_d  = gnt_q;
    data_d = data_q;
    if (state_q == IDLE) begin
      gnt_d = '0;
      if (any_req) begin
        sel_d  = winner;
        gnt_d  = onehot2(winner);
        data_d = words[winner];
      end
    end else if (hs) begin
      gnt_d = '0;
      // a locked winner leaves ptr one behind so it is scanned first again
      ptr_d = keep ? sel_q - SEL_W'(1) : sel_q;
    end
  end

  always_comb begin
    out_valid = (state_q == GRANT);
    busy      = (state_q == GRANT);
  end

  assign out_data = data_q;
  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign ack      = gnt_q & {N_REQ{out_valid & out_ready}};
endmodule

// File: tb/tb_rr_arbiter4_4bits.sv
// Self-checking bench for rr_arbiter4_4bits: vector table, corner sequences, random vs model.
module tb_rr_arbiter4_4bits;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ins [4];
  logic       out_ready;
  logic [3:0] lock;
  logic       out_valid, busy;
  logic [3:0] out_data, gnt, ack;
  logic [1:0] sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter4_4bits dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (ins[0]),
    .in1       (ins[1]),
    .in2       (ins[2]),
    .in3       (ins[3]),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    int         win;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ov, gnt, sel, data, ack, busy in one go
  task automatic chk_all(input string tag, input logic ov, input logic [3:0] g, input logic [1:0] s,
                         input logic [3:0] d, input logic [3:0] a);
    chk({tag, ".out_valid"}, out_valid, ov);
    chk({tag, ".busy"}, busy, ov);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".sel"}, sel, s);
    chk({tag, ".out_data"}, out_data, d);
    chk({tag, ".ack"}, ack, a);
  endtask

  // one full transaction starting in IDLE at edge+1 with out_ready=1
  task automatic xact(input string tag, input logic [3:0] r, input logic [3:0] lk, input int w);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    req = r; lock = lk; out_ready = 1'b1;
    #1 chk({tag, ".idle_valid"}, out_valid, 1'b0);
    tick();
    chk_all({tag, ".grant"}, 1'b1, oh, 2'(w), ins[w], oh);
    req = 4'b0000;
    tick();
    chk_all({tag, ".after"}, 1'b0, 4'b0000, 2'(w), ins[w], 4'b0000);
  endtask

  vec_t vt [12];

  // reference model state
  int         m_ptr, m_w;
  bit         m_busy;
  logic [1:0] m_sel;
  logic [3:0] m_data;

  initial begin
    vt[0]  = '{4'b0001, 4'b0, 0};
    vt[1]  = '{4'b1111, 4'b0, 1};
    vt[2]  = '{4'b1111, 4'b0, 2};
    vt[3]  = '{4'b1111, 4'b0, 3};
    vt[4]  = '{4'b1111, 4'b0, 0};
    vt[5]  = '{4'b1000, 4'b0, 3};
    vt[6]  = '{4'b1001, 4'b0, 0};
    vt[7]  = '{4'b1001, 4'b0, 3};
    vt[8]  = '{4'b0100, 4'b0, 2};
    vt[9]  = '{4'b0011, 4'b0, 0};
    vt[10] = '{4'b0110, 4'b0, 1};
    vt[11] = '{4'b0110, 4'b0, 2};

    rst = 1'b1; req = '0; out_ready = 1'b0; lock = '0;
    ins[0] = 4'hA; ins[1] = 4'h6; ins[2] = 4'h7; ins[3] = 4'h8;
    #1 chk_all("reset", 1'b0, 4'b0000, 2'd0, 4'h0, 4'b0000);
    #11 rst = 1'b0;
    tick();

    foreach (vt[i]) xact($sformatf("vec%0d", i), vt[i].req, vt[i].lock, vt[i].win);

    // hold under backpressure: word, grant and sel frozen, no ack
    ins[2] = 4'h5; req = 4'b0100; out_ready = 1'b0;
    tick();
    chk_all("hold.grant", 1'b1, 4'b0100, 2'd2, 4'h5, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      ins[2] = 4'hF; req = 4'b1011;
      tick();
      chk_all($sformatf("hold.c%0d", c), 1'b1, 4'b0100, 2'd2, 4'h5, 4'b0000);
    end
    out_ready = 1'b1;
    #1 chk("hold.ack", ack, 4'b0100);
    req = '0;
    tick();
    chk("hold.release", out_valid, 1'b0);

    // async reset in the middle of a grant
    ins[2] = 4'h7; req = 4'b0001; out_ready = 1'b0;
    tick();
    chk("arst.pre_valid", out_valid, 1'b1);
    #2 rst = 1'b1; out_ready = 1'b1;
    #1 chk_all("arst.now", 1'b0, 4'b0000, 2'd0, 4'h0, 4'b0000);
    req = '0;
    tick();
    rst = 1'b0;

    // back-to-back with req held: one word per two cycles, order 0,1,2,3,0
    ins[0] = 4'h1; ins[1] = 4'h2; ins[2] = 4'h3; ins[3] = 4'h4;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("tput%0d.grant", i), 1'b1, 4'b0001 << (i % 4), 2'(i % 4),
              4'(i % 4 + 1), 4'b0001 << (i % 4));
      tick();
      chk($sformatf("tput%0d.gap", i), out_valid, 1'b0);
    end
    req = '0;

`ifdef ARB_LOCK_EN
    xact("lock0", 4'b0110, 4'b0010, 1);
    xact("lock1", 4'b0110, 4'b0010, 1);
    xact("lock2", 4'b0110, 4'b0000, 1);
    xact("lock3", 4'b0110, 4'b0000, 2);
`endif

    // randomized run against the behavioural model
    rst = 1'b1; lock = '0;
    #1 rst = 1'b0;
    m_ptr = 3; m_busy = 0; m_w = 0; m_sel = 0; m_data = 0;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] eg;
      req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) ins[k] = 4'($urandom_range(0, 15));
`ifdef ARB_LOCK_EN
      lock = 4'($urandom_range(0, 15));
`endif
      #1;
      eg = m_busy ? (4'b0001 << m_w) : 4'b0000;
      chk_all($sformatf("rnd%0d", cyc), m_busy, eg, m_sel, m_data, out_ready ? eg : 4'b0000);
      if (m_busy) begin
        if (out_ready) begin
          m_ptr = m_w;
`ifdef ARB_LOCK_EN
          if (lock[m_w]) m_ptr = (m_w + 3) % 4;
`endif
          m_busy = 0;
        end
      end else if (req != 0) begin
        for (int k = 1; k <= 4; k++)
          if (req[(m_ptr + k) % 4]) begin
            m_w = (m_ptr + k) % 4;
            break;
          end
        m_sel = 2'(m_w); m_data = ins[m_w]; m_busy = 1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
